// File: rtl/fbra_pixel_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fbra_pixel_scheduler                                             |
// | Purpose  : Per-pixel sequencer feeding channel samples to the beamforming   |
// |            core and returning its result over a valid/ready handshake.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module fbra_pixel_scheduler #(
   parameter int CHANNELS     = 128,
   parameter int CH_W         = 8,
   parameter int PIX_W        = 16,
   parameter int CORE_LATENCY = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic [PIX_W-1:0]        i_req_pixel,
   input  logic                    i_req_mode,
   output logic                    o_mem_rd_en,
   output logic [PIX_W-1:0]        o_mem_pixel,
   output logic [CH_W-1:0]         o_mem_chan,
   input  logic signed [15:0]      i_mem_rdata,
   output logic                    o_core_rst,
   output logic                    o_core_mode,
   output logic signed [15:0]      o_core_rfdata,
   input  logic signed [16:0]      i_core_bf_out,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic signed [16:0]      o_out_data,
   output logic [PIX_W-1:0]        o_out_pixel,
   output logic                    o_out_mode,
   output logic                    o_busy,
   output logic [PIX_W-1:0]        o_pixels_done
);

   localparam int              WAIT_W      = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
   localparam logic [CH_W-1:0]   c_last_chan = CH_W'(CHANNELS - 1);
   localparam logic [WAIT_W-1:0] c_wait_init = WAIT_W'(CORE_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRIME  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_WAIT   = 3'd4,
      S_OUT    = 3'd5
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [PIX_W-1:0]       r_pix;
   logic                   r_mode;
   logic [CH_W-1:0]        r_chan;
   logic [WAIT_W-1:0]      r_wait;
   logic signed [16:0]     r_out_data;
   logic [PIX_W-1:0]       r_out_pixel;
   logic                   r_out_mode;
   logic [PIX_W-1:0]       r_pixels_done;

   logic                   w_req_ready;
   logic                   w_rd_en;
   logic [CH_W-1:0]        w_mem_chan;
   logic                   w_core_rst;
   logic                   w_pass_sample;
   logic                   w_out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_req_ready   = 1'b0;
      w_rd_en       = 1'b0;
      w_mem_chan    = '0;
      w_core_rst    = 1'b0;
      w_pass_sample = 1'b0;
      w_out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (i_req_valid) begin
               w_state_nxt = S_PRIME;
            end
         end
         S_PRIME: begin
            w_core_rst  = 1'b1;
            w_rd_en     = 1'b1;
            w_state_nxt = S_STREAM;
         end
         // Read data lags the address by one cycle, so the core sees channel r_chan-1.
         S_STREAM: begin
            w_rd_en       = 1'b1;
            w_mem_chan    = r_chan;
            w_pass_sample = 1'b1;
            if (r_chan == c_last_chan) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_pass_sample = 1'b1;
            w_state_nxt   = S_WAIT;
         end
         S_WAIT: begin
            if (r_wait == '0) begin
               w_state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            w_out_valid = 1'b1;
            if (i_out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix         <= '0;
         r_mode        <= 1'b0;
         r_chan        <= '0;
         r_wait        <= '0;
         r_out_data    <= '0;
         r_out_pixel   <= '0;
         r_out_mode    <= 1'b0;
         r_pixels_done <= '0;
      end else begin
         if (r_state == S_IDLE && i_req_valid) begin
            r_pix  <= i_req_pixel;
            r_mode <= i_req_mode;
         end
         if (r_state == S_PRIME) begin
            r_chan <= CH_W'(1);
         end else if (r_state == S_STREAM) begin
            r_chan <= r_chan + 1'b1;
         end
         if (r_state == S_DRAIN) begin
            r_wait <= c_wait_init;
         end else if (r_state == S_WAIT) begin
            r_wait <= r_wait - 1'b1;
         end
         if (r_state == S_WAIT && r_wait == '0) begin
            r_out_data  <= i_core_bf_out;
            r_out_pixel <= r_pix;
            r_out_mode  <= r_mode;
         end
         if (r_state == S_OUT && i_out_ready) begin
            r_pixels_done <= r_pixels_done + 1'b1;
         end
      end
   end

   // Reset is synchronous, so outputs are masked by rst to be quiet from its first cycle.
   assign o_req_ready   = w_req_ready & ~rst;
   assign o_mem_rd_en   = w_rd_en & ~rst;
   assign o_mem_pixel   = (w_rd_en && !rst) ? r_pix : '0;
   assign o_mem_chan    = rst ? '0 : w_mem_chan;
   assign o_core_rst    = rst | w_core_rst;
   assign o_core_mode   = r_mode & ~rst;
   assign o_core_rfdata = (w_pass_sample && !rst) ? i_mem_rdata : '0;
   assign o_out_valid   = w_out_valid & ~rst;
   assign o_out_data    = rst ? '0 : r_out_data;
   assign o_out_pixel   = rst ? '0 : r_out_pixel;
   assign o_out_mode    = r_out_mode & ~rst;
   assign o_busy        = (r_state != S_IDLE) & ~rst;
   assign o_pixels_done = rst ? '0 : r_pixels_done;

endmodule
`default_nettype wire

// File: doc/fbra_pixel_scheduler.md
Name: fbra_pixel_scheduler

Overview:
- Sequences the pixel-level reconfigurable beamforming core, one pixel at a time.
- Per pixel: accepts a request (pixel index plus DAS/DMAS mode), pulses the core reset, and streams all channel samples for that pixel from the delayed-sample memory into the core.
- Then waits the core's fixed result latency, captures the 17-bit beamformed value and hands it downstream with a valid/ready handshake.
- Sits between the frame/pixel controller and the beamforming core wrapper.

Parameters:
- CHANNELS, 128, samples per pixel; the core consumes one sample per cycle.
- CH_W, 8, channel index width; must satisfy 2^CH_W >= CHANNELS.
- PIX_W, 16, pixel index width.
- CORE_LATENCY, 12, cycles from the last sample presented to core_bf_out being valid.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, 1, pixel request valid.
- req_ready, output, 1, scheduler can accept a request.
- req_pixel, input, PIX_W, pixel index.
- req_mode, input, 1, 0 = DMAS, 1 = DAS.
- mem_rd_en, output, 1, sample memory read strobe.
- mem_pixel, output, PIX_W, read pixel index.
- mem_chan, output, CH_W, read channel index.
- mem_rdata, input, 16 signed, read data; valid exactly 1 cycle after mem_rd_en.
- core_rst, output, 1, beamforming core reset.
- core_mode, output, 1, core mode select.
- core_rfdata, output, 16 signed, sample to core.
- core_bf_out, input, 17 signed, core result.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, 17 signed, beamformed pixel value.
- out_pixel, output, PIX_W, pixel index of out_data.
- out_mode, output, 1, mode used for out_data.
- busy, output, 1, high in every state except IDLE.
- pixels_done, output, PIX_W, count of completed output handshakes; wraps modulo 2^PIX_W.

Behaviour:
- Reset (rst=1):
  - State goes to IDLE.
  - core_rst=1 for the whole reset.
  - All other outputs are 0, including req_ready, out_*, mem_*, core_mode, core_rfdata, busy and pixels_done.
  - Reset mid-pixel abandons the pixel; no output is produced for it.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid & req_ready.
  - On acceptance: latch req_pixel into pix_r and req_mode into mode_r, then go to PRIME.
- PRIME (1 cycle):
  - core_rst=1, mem_rd_en=1, mem_chan=0, mem_pixel=pix_r, core_rfdata=0.
  - Next state is STREAM.
- STREAM (CHANNELS-1 cycles):
  - mem_rd_en=1, with mem_chan counting 1..CHANNELS-1.
  - core_rfdata=mem_rdata, i.e. the sample for channel mem_chan-1.
  - After mem_chan=CHANNELS-1 is issued, go to DRAIN.
- DRAIN (1 cycle):
  - mem_rd_en=0.
  - core_rfdata=mem_rdata, the sample for channel CHANNELS-1.
  - Next state is WAIT.
- Sample stream guarantee: exactly CHANNELS consecutive samples reach the core, in channels order 0..CHANNELS-1.
  - The first sample arrives in the first cycle after core_rst deasserts.
  - core_rfdata=0 in every other cycle.
- WAIT (CORE_LATENCY cycles, down-counter):
  - At the end of the last WAIT cycle, register core_bf_out into out_data, pix_r into out_pixel and mode_r into out_mode.
  - Next state is OUT.
- OUT:
  - out_valid=1; out_data, out_pixel and out_mode are held stable.
  - On out_valid & out_ready: increment pixels_done, drop out_valid and return to IDLE.
  - While out_ready=0, stay in OUT indefinitely; req_ready stays 0, so there is no overwrite and no loss.
- core_mode:
  - Driven from mode_r from the PRIME cycle through OUT.
  - Retains its last value while IDLE.
  - req_mode and req_pixel changes after acceptance are ignored.
- Throughput: CHANNELS + CORE_LATENCY + 3 cycles per pixel with out_ready held high; IDLE imposes one bubble cycle between pixels.
- Data handling: no arithmetic is applied to the data; sign and width pass through unchanged.

Test Plan:
- Single pixel, DMAS (CHANNELS=4, CORE_LATENCY=3): request pixel 5, mode 0.
  - Required: core_rst high for 1 cycle, then core_rfdata = mem[5][0..3] on 4 consecutive cycles.
  - Required: out_valid rises 3 cycles after DRAIN, with out_pixel=5, out_mode=0 and out_data equal to core_bf_out sampled at that point; pixels_done=1.
- Back-to-back requests with req_valid held high (pixel 1 mode 1, then pixel 2 mode 0), out_ready=1.
  - Required: second PRIME starts exactly 2 cycles after the first out_valid.
  - Required: core_mode switches 1→0 only at the second PRIME; pixels_done=2.
- Output backpressure: hold out_ready=0 for 20 cycles after out_valid rises.
  - Required: out_data/out_pixel stable, req_ready=0, no mem_rd_en.
  - Required: when out_ready is released, exactly one handshake occurs.
- Reset mid-STREAM: assert rst at mem_chan=2.
  - Required: next cycle IDLE, all outputs 0, core_rst=1, pixels_done=0, no out_valid.
  - Required: a fresh request then completes normally.
- Negative and extreme samples: mem values -32768, 32767, -1, 0.
  - Required: core_rfdata reproduces them bit-exact and in order.
  - Required: core_bf_out value -65536 is passed to out_data unchanged.
- pixels_done wrap (PIX_W=4): run 17 pixels.
  - Required: pixels_done reads 1 after the 17th handshake.
